// File: rtl/regex_cpu_memory_arbiter_pkg.sv
// Shared regex CPU package: instruction word constants, opcode encoding and
// the instruction-memory arbiter state encoding.
package regex_cpu_memory_arbiter_pkg;

  localparam int unsigned INSTR_WIDTH      = 20;
  localparam int unsigned INSTR_ADDR_WIDTH = 11;
  localparam int unsigned OPCODE_WIDTH     = 3;
  localparam int unsigned OPERAND_WIDTH    = INSTR_WIDTH - OPCODE_WIDTH;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_CHAR   = 3'd0,
    OP_ANY    = 3'd1,
    OP_JMP    = 3'd2,
    OP_SPLIT  = 3'd3,
    OP_MATCH  = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regex_cpu_memory_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or above i_ptr, wrapping.
module rr_priority_picker
  import regex_cpu_memory_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_found_c
);

  logic [IDX_W-1:0] w_pos;

  // Walk from farthest to nearest so the nearest hit to i_ptr is the one kept.
  always_comb begin
    o_idx_c   = '0;
    o_found_c = 1'b0;
    w_pos     = '0;
    for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
      w_pos = i_ptr + IDX_W'(k);
      if (i_req[w_pos]) begin
        o_idx_c   = w_pos;
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regex_cpu_memory_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port among NUM_CPUS
// regex CPUs, with a single outstanding memory transaction.
module regex_cpu_memory_arbiter
  import regex_cpu_memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CPUS          = 4,
  parameter int unsigned MEMORY_WIDTH      = INSTR_WIDTH,
  parameter int unsigned MEMORY_ADDR_WIDTH = INSTR_ADDR_WIDTH,
  parameter int unsigned CPU_ID_BITS       = $clog2(NUM_CPUS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CPUS-1:0]                   cpu_memory_valid,
  input  logic [NUM_CPUS*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
  output logic [NUM_CPUS-1:0]                   cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]               cpu_memory_data,
  output logic                                  memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]          memory_addr,
  input  logic                                  memory_ready,
  input  logic [MEMORY_WIDTH-1:0]               memory_data,
  output logic [CPU_ID_BITS-1:0]                grant_id,
  output logic                                  busy
);

  arb_state_t                   r_state,     w_state;
  logic [CPU_ID_BITS-1:0]       r_rr_ptr,    w_rr_ptr;
  logic [NUM_CPUS-1:0]          r_mask,      w_mask;
  logic                         r_mem_valid, w_mem_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr;
  logic [NUM_CPUS-1:0]          r_cpu_ready, w_cpu_ready;
  logic [MEMORY_WIDTH-1:0]      r_cpu_data,  w_cpu_data;
  logic [CPU_ID_BITS-1:0]       r_grant_id,  w_grant_id;
  logic                         r_busy,      w_busy;

  logic [MEMORY_ADDR_WIDTH-1:0] w_cpu_addr [NUM_CPUS];
  logic [NUM_CPUS-1:0]          w_req;
  logic [CPU_ID_BITS-1:0]       w_pick_idx;
  logic                         w_pick_found;

  for (genvar g = 0; g < NUM_CPUS; g++) begin : g_addr_unpack
    assign w_cpu_addr[g] = cpu_memory_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  // The one-cycle mask hides the CPU just served while its stale valid drains.
  assign w_req = cpu_memory_valid & ~r_mask;

  rr_priority_picker #(
    .WIDTH (NUM_CPUS),
    .IDX_W (CPU_ID_BITS)
  ) u_picker (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .o_idx_c   (w_pick_idx),
    .o_found_c (w_pick_found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_mask      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_cpu_ready <= '0;
      r_cpu_data  <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_rr_ptr    <= w_rr_ptr;
      r_mask      <= w_mask;
      r_mem_valid <= w_mem_valid;
      r_mem_addr  <= w_mem_addr;
      r_cpu_ready <= w_cpu_ready;
      r_cpu_data  <= w_cpu_data;
      r_grant_id  <= w_grant_id;
      r_busy      <= w_busy;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_rr_ptr    = r_rr_ptr;
    w_mask      = r_mask;
    w_mem_valid = r_mem_valid;
    w_mem_addr  = r_mem_addr;
    w_cpu_ready = '0;
    w_cpu_data  = r_cpu_data;
    w_grant_id  = r_grant_id;
    w_busy      = r_busy;

    unique case (r_state)
      IDLE: begin
        w_mask = '0;
        if (w_pick_found) begin
          w_state     = GRANT;
          w_mem_valid = 1'b1;
          w_mem_addr  = w_cpu_addr[w_pick_idx];
          w_grant_id  = w_pick_idx;
          w_rr_ptr    = w_pick_idx + CPU_ID_BITS'(1);
          w_busy      = 1'b1;
        end
      end
      GRANT: begin
        if (memory_ready) begin
          w_state     = RESP;
          w_mem_valid = 1'b0;
          w_cpu_data  = memory_data;
          w_cpu_ready = NUM_CPUS'(1) << r_grant_id;
        end
      end
      RESP: begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_mask  = NUM_CPUS'(1) << r_grant_id;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign cpu_memory_ready = r_cpu_ready;
  assign cpu_memory_data  = r_cpu_data;
  assign memory_valid     = r_mem_valid;
  assign memory_addr      = r_mem_addr;
  assign grant_id         = r_grant_id;
  assign busy             = r_busy;

endmodule

// File: doc/regex_cpu_memory_arbiter.md
# regex_cpu_memory_arbiter

Round-robin arbiter that shares one instruction-memory port among `NUM_CPUS` regex CPUs. Each CPU keeps its usual fetch handshake: `valid` plus address out, a one-cycle `ready` pulse plus data back. The arbiter sits between the CPU array and the single instruction memory. It serialises fetches with exactly one outstanding memory transaction and guarantees that no requester starves.

## Interface
Parameters:
- `NUM_CPUS`, 4: number of requesting CPUs; must be a power of two, at least 2.
- `MEMORY_WIDTH`, 20: instruction word width.
- `MEMORY_ADDR_WIDTH`, 11: memory address width.
- `CPU_ID_BITS`, $clog2(NUM_CPUS): width of the grant index.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous and active-low.
- `cpu_memory_valid` in NUM_CPUS: per-CPU fetch request.
- `cpu_memory_addr` in NUM_CPUS*MEMORY_ADDR_WIDTH: packed addresses; slice i belongs to CPU i.
- `cpu_memory_ready` out NUM_CPUS: one-hot one-cycle response pulse.
- `cpu_memory_data` out MEMORY_WIDTH: response word broadcast to all CPUs; valid only where the matching `cpu_memory_ready` bit is 1.
- `memory_valid` out 1: request to memory.
- `memory_addr` out MEMORY_ADDR_WIDTH: request address.
- `memory_ready` in 1: memory response strobe.
- `memory_data` in MEMORY_WIDTH: memory response word, sampled when `memory_ready` is 1.
- `grant_id` out CPU_ID_BITS: index of the current or last grantee.
- `busy` out 1: high while in GRANT or RESP.

## Operation
- FSM has three states:
  - IDLE → GRANT when at least one unmasked `cpu_memory_valid` bit is 1.
  - GRANT → RESP on `memory_ready`.
  - RESP → IDLE unconditionally.
- **Arbitration in IDLE:** search starts at `rr_ptr` and proceeds upward with wrap-around. The first set bit of `cpu_memory_valid & ~mask` wins and becomes `grant_id`.
- **On grant:**
  - Register `memory_valid = 1` and `memory_addr` = the grantee's address slice.
  - Set `rr_ptr = grant_id + 1` modulo NUM_CPUS; natural wrap on CPU_ID_BITS.
  - Clear `mask`.
- **GRANT state:**
  - Hold `memory_valid` and `memory_addr` stable until `memory_ready`.
  - Later changes on `cpu_memory_addr` are ignored, because the address was captured at grant.
  - On `memory_ready`: capture `memory_data`, drop `memory_valid` on the same edge, enter RESP.
- **RESP state:**
  - `cpu_memory_ready[grant_id] = 1` for exactly this cycle.
  - `cpu_memory_data` = the captured word.
  - Set `mask = onehot(grant_id)` for the following IDLE cycle only.
- **Requester rule:** a CPU deasserts `cpu_memory_valid` in the cycle after it sees its ready pulse. The one-cycle mask guarantees the same CPU is not re-granted by a stale `valid`.
- **Abandoned request:** a CPU may drop `cpu_memory_valid` while in GRANT. The arbiter still completes the memory transaction and still pulses that CPU's ready bit in RESP.
- **Simultaneous events:** `memory_ready` while in IDLE or RESP is ignored, since no transaction is outstanding.

## Timing
- **Reset values (asserted asynchronously):** state = IDLE, `rr_ptr` = 0, `mask` = 0, `memory_valid` = 0, `memory_addr` = 0, `cpu_memory_ready` = 0, `cpu_memory_data` = 0, `grant_id` = 0, `busy` = 0.
- **Reset mid-transaction:** the outstanding fetch is dropped. The memory is reset in the same domain and must also discard it.
- **Request path:** CPU `valid` seen in cycle t (state IDLE) → `memory_valid` = 1 in t+1.
- **Response path:** `memory_ready` in cycle m → `cpu_memory_ready` pulse in m+1. The next grant is registered at the edge ending m+2, so the next `memory_valid` is first high in m+3.
- **Throughput with zero-wait memory** (`memory_ready` in the first GRANT cycle): one fetch per 3 cycles.
- **Worst-case wait** for a continuously requesting CPU: NUM_CPUS-1 other transactions.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Arbiter states enum `arb_state_t` (IDLE, GRANT, RESP) goes in the shared instruction/CPU package alongside the existing instruction constants.
- The round-robin priority picker is one natural sub-module, `rr_priority_picker`, parameterised by width. It is purely combinational: inputs are request vector and pointer; outputs are index and found flag.
- No other sub-modules.

## Test plan
- **Single requester:** NUM_CPUS=4, CPU 2 requests addr 0x0F5, memory returns 20'h1F041 after 2 wait cycles → `memory_addr`=0x0F5; `cpu_memory_ready`=4'b0100 for 1 cycle with data 20'h1F041; `grant_id`=2; `busy` low afterwards.
- **All four request at once after reset:** grants issue in order 0,1,2,3. Each CPU receives its own addresses 0x100..0x103, and every `cpu_memory_ready` is one-hot.
- **Fairness:** CPUs 0 and 3 request continuously, re-raising after each pulse → grants alternate 0,3,0,3 for 20 transactions; no two consecutive grants go to the same CPU.
- **Address change during GRANT:** CPU 1 changes `cpu_memory_addr` from 0x050 to 0x060 before `memory_ready` → `memory_addr` stays 0x050 throughout.
- **Stale valid masking:** CPU 0 holds `valid` one extra cycle after its pulse while CPU 1 is idle → no second grant to CPU 0 within the masked cycle.
- **Reset mid-transaction:** `rst` driven low while in GRANT with `memory_valid`=1 → all outputs 0 asynchronously. After `rst` returns high, a new request from CPU 3 is granted with `rr_ptr` starting from 0.
